// File: rtl/bulls_cows_scorer_if.sv
// Handshake bundle for the Bulls & Cows scorer.
//   master : producer of secret/guess pairs and consumer of results (game FSM / bench)
//   slave  : the scorer itself
// Signals: in_valid/in_ready + secret/guess on the request side,
//          out_valid/out_ready + bulls/cows/win/err on the response side.
interface bulls_cows_scorer_if #(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = 4,
  parameter int CNT_W    = $clog2(N_DIGITS + 1)
);
  logic                        in_valid;
  logic                        in_ready;
  logic [N_DIGITS*DIGIT_W-1:0] secret;
  logic [N_DIGITS*DIGIT_W-1:0] guess;
  logic                        out_valid;
  logic                        out_ready;
  logic [CNT_W-1:0]            bulls;
  logic [CNT_W-1:0]            cows;
  logic                        win;
  logic                        err;

  modport master (
    output in_valid, secret, guess, out_ready,
    input  in_ready, out_valid, bulls, cows, win, err
  );

  modport slave (
    input  in_valid, secret, guess, out_ready,
    output in_ready, out_valid, bulls, cows, win, err
  );
endinterface

// File: rtl/bulls_cows_scorer.sv
// Bulls & Cows scoring engine.
// Captures one secret/guess pair in IDLE, optionally walks the digits looking
// for repeats (CHECK), then scores one digit per cycle (SCORE) and holds the
// result in DONE until the consumer takes it.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : bulls_cows_scorer_if.slave (request/response handshakes + result)
module bulls_cows_scorer #(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = 4,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  bulls_cows_scorer_if.slave bus
);
  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ALL  = CNT_W'(N_DIGITS);

  typedef enum logic [1:0] {IDLE, CHECK, SCORE, DONE} state_t;

  state_t state_q, state_d;

  logic [N_DIGITS-1:0][DIGIT_W-1:0] sec_q, gss_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [CNT_W-1:0]                 cnt_b, cnt_c;
  logic                             err_acc;

  // Result registers are separate from the running counters so the ports
  // never show a half-finished score.
  logic [CNT_W-1:0] bulls_o, cows_o;
  logic             win_o, err_o, out_valid_q;

  logic [DIGIT_W-1:0] g_cur, s_cur;
  logic               last, dup_hit, cow_hit, bull_hit;
  logic [CNT_W-1:0]   b_nxt, c_nxt;

  assign g_cur    = gss_q[idx_q];
  assign s_cur    = sec_q[idx_q];
  assign last     = (idx_q == IDX_LAST);
  assign bull_hit = (g_cur == s_cur);

  // Per-digit compare: repeats only look forward (j > idx) so each pair is
  // examined once; cow search looks at every other secret position.
  always_comb begin
    dup_hit = 1'b0;
    cow_hit = 1'b0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j > int'(idx_q)) begin
        if (gss_q[j] == g_cur || sec_q[j] == s_cur) dup_hit = 1'b1;
      end
      if (j != int'(idx_q) && sec_q[j] == g_cur) cow_hit = 1'b1;
    end
    b_nxt = cnt_b + CNT_W'(bull_hit);
    c_nxt = cnt_c + CNT_W'(!bull_hit && cow_hit);
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid) state_d = CHECK_EN ? CHECK : SCORE;
      CHECK: if (last) state_d = (err_acc || dup_hit) ? DONE : SCORE;
      SCORE: if (last) state_d = DONE;
      DONE:  if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sec_q       <= '0;
      gss_q       <= '0;
      idx_q       <= '0;
      cnt_b       <= '0;
      cnt_c       <= '0;
      err_acc     <= 1'b0;
      bulls_o     <= '0;
      cows_o      <= '0;
      win_o       <= 1'b0;
      err_o       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // idx restarts on every state change and only advances while walking digits
      if (state_d != state_q)                  idx_q <= '0;
      else if (state_q == CHECK || state_q == SCORE) idx_q <= idx_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sec_q   <= bus.secret;
            gss_q   <= bus.guess;
            cnt_b   <= '0;
            cnt_c   <= '0;
            err_acc <= 1'b0;
            bulls_o <= '0;
            cows_o  <= '0;
            win_o   <= 1'b0;
            err_o   <= 1'b0;
          end
        end
        CHECK: begin
          if (dup_hit) err_acc <= 1'b1;
          if (last && (err_acc || dup_hit)) begin
            bulls_o <= '0;
            cows_o  <= '0;
            win_o   <= 1'b0;
            err_o   <= 1'b1;
          end
        end
        SCORE: begin
          cnt_b <= b_nxt;
          cnt_c <= c_nxt;
          if (last) begin
            bulls_o <= b_nxt;
            cows_o  <= c_nxt;
            win_o   <= (b_nxt == CNT_ALL);
            err_o   <= 1'b0;
          end
        end
        DONE: begin
          // out_valid rises one edge after DONE entry; the handshake only
          // completes once it has been seen high.
          if (!out_valid_q)         out_valid_q <= 1'b1;
          else if (bus.out_ready)   out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.bulls     = bulls_o;
  assign bus.cows      = cows_o;
  assign bus.win       = win_o;
  assign bus.err       = err_o;
endmodule
